// File: rtl/move_checker_pkg.sv
// Shared move-checker definitions: move codes, board defaults,
// FSM states, shape indices and an offset-table packing helper.
package tetris_pkg;

    localparam int BOARD_W_DEF = 10;
    localparam int BOARD_H_DEF = 24;

    localparam logic [1:0] MOVE_DOWN  = 2'd0;
    localparam logic [1:0] MOVE_LEFT  = 2'd1;
    localparam logic [1:0] MOVE_RIGHT = 2'd2;
    localparam logic [1:0] MOVE_ROT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PROBE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    localparam logic [2:0] SHAPE_I = 3'd0;
    localparam logic [2:0] SHAPE_O = 3'd1;
    localparam logic [2:0] SHAPE_T = 3'd2;
    localparam logic [2:0] SHAPE_S = 3'd3;
    localparam logic [2:0] SHAPE_Z = 3'd4;
    localparam logic [2:0] SHAPE_J = 3'd5;
    localparam logic [2:0] SHAPE_L = 3'd6;

    // Four cells, 2-bit offsets; cell 0 sits in the low bits.
    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
    } offs_t;

    function automatic offs_t cells(
        input int x0, input int y0,
        input int x1, input int y1,
        input int x2, input int y2,
        input int x3, input int y3
    );
        offs_t r;
        r.x = {2'(x3), 2'(x2), 2'(x1), 2'(x0)};
        r.y = {2'(y3), 2'(y2), 2'(y1), 2'(y0)};
        return r;
    endfunction

endpackage

// File: rtl/move_checker_if.sv
// Control/RAM bundle between game FSM, move checker and board RAM.
// master: request + RAM data out, results in; slave: the checker.
interface move_checker_if #(
    parameter int X_W      = 5,
    parameter int Y_W      = 6,
    parameter int ADDR_W   = 8,
    parameter int COLOUR_W = 6
);
    logic                start;
    logic [1:0]          move;
    logic [X_W-1:0]      x_anchor;
    logic [Y_W-1:0]      y_anchor;
    logic [2:0]          block;
    logic [1:0]          rot;
    logic [COLOUR_W-1:0] ram_q;
    logic [ADDR_W-1:0]   ram_addr;
    logic                busy;
    logic                done;
    logic                blocked;
    logic                landed;
    logic [X_W-1:0]      x_out;
    logic [Y_W-1:0]      y_out;
    logic [1:0]          rot_out;

    modport master (
        output start, move, x_anchor, y_anchor,
        output block, rot, ram_q,
        input  ram_addr, busy, done, blocked,
        input  landed, x_out, y_out, rot_out
    );

    modport slave (
        input  start, move, x_anchor, y_anchor,
        input  block, rot, ram_q,
        output ram_addr, busy, done, blocked,
        output landed, x_out, y_out, rot_out
    );

endinterface

// File: rtl/move_checker_offsets.sv
// piece_offsets: (block_i, rot_i) -> packed per-cell X/Y offsets
// (offx_o, offy_o, cell i at [i*OFF_W +: OFF_W]) and colour_o.
module piece_offsets
    import tetris_pkg::*;
#(
    parameter int CELLS    = 4,
    parameter int OFF_W    = 2,
    parameter int COLOUR_W = 6
) (
    input  logic [2:0]             block_i,
    input  logic [1:0]             rot_i,
    output logic [CELLS*OFF_W-1:0] offx_o,
    output logic [CELLS*OFF_W-1:0] offy_o,
    output logic [COLOUR_W-1:0]    colour_o
);

    localparam int OW = CELLS * OFF_W;

    offs_t      o;
    logic [5:0] c;

    always_comb begin
        o = cells(0, 0, 1, 0, 0, 1, 1, 1);
        c = 6'h00;
        case (block_i)
            SHAPE_I: begin
                c = 6'h1B;
                case (rot_i)
                    2'd0: o = cells(1, 0, 1, 1, 1, 2, 1, 3);
                    2'd1: o = cells(0, 1, 1, 1, 2, 1, 3, 1);
                    2'd2: o = cells(2, 0, 2, 1, 2, 2, 2, 3);
                    default: o = cells(0, 2, 1, 2, 2, 2, 3, 2);
                endcase
            end
            SHAPE_O: c = 6'h3C;
            SHAPE_T: begin
                c = 6'h22;
                case (rot_i)
                    2'd0: o = cells(1, 0, 0, 1, 1, 1, 2, 1);
                    2'd1: o = cells(1, 0, 1, 1, 2, 1, 1, 2);
                    2'd2: o = cells(0, 1, 1, 1, 2, 1, 1, 2);
                    default: o = cells(1, 0, 0, 1, 1, 1, 1, 2);
                endcase
            end
            SHAPE_S: begin
                c = 6'h0C;
                case (rot_i)
                    2'd0: o = cells(1, 0, 2, 0, 0, 1, 1, 1);
                    2'd1: o = cells(1, 0, 1, 1, 2, 1, 2, 2);
                    2'd2: o = cells(1, 1, 2, 1, 0, 2, 1, 2);
                    default: o = cells(0, 0, 0, 1, 1, 1, 1, 2);
                endcase
            end
            SHAPE_Z: begin
                c = 6'h30;
                case (rot_i)
                    2'd0: o = cells(0, 0, 1, 0, 1, 1, 2, 1);
                    2'd1: o = cells(2, 0, 1, 1, 2, 1, 1, 2);
                    2'd2: o = cells(0, 1, 1, 1, 1, 2, 2, 2);
                    default: o = cells(1, 0, 0, 1, 1, 1, 0, 2);
                endcase
            end
            SHAPE_J: begin
                c = 6'h03;
                case (rot_i)
                    2'd0: o = cells(0, 0, 0, 1, 1, 1, 2, 1);
                    2'd1: o = cells(1, 0, 2, 0, 1, 1, 1, 2);
                    2'd2: o = cells(0, 1, 1, 1, 2, 1, 2, 2);
                    default: o = cells(1, 0, 1, 1, 0, 2, 1, 2);
                endcase
            end
            SHAPE_L: begin
                c = 6'h34;
                case (rot_i)
                    2'd0: o = cells(2, 0, 0, 1, 1, 1, 2, 1);
                    2'd1: o = cells(1, 0, 1, 1, 1, 2, 2, 2);
                    2'd2: o = cells(0, 1, 1, 1, 2, 1, 0, 2);
                    default: o = cells(0, 0, 1, 0, 1, 1, 1, 2);
                endcase
            end
            default: c = 6'h00;
        endcase
    end

    assign offx_o   = OW'(o.x);
    assign offy_o   = OW'(o.y);
    assign colour_o = COLOUR_W'(c);

endmodule

// File: rtl/move_checker.sv
// move_checker: probes board RAM one target cell per cycle for a move.
// Ports: clk, reset (sync, active high), bus (move_checker_if.slave).
module move_checker
    import tetris_pkg::*;
#(
    parameter int BOARD_W  = BOARD_W_DEF,
    parameter int BOARD_H  = BOARD_H_DEF,
    parameter int X_W      = 5,
    parameter int Y_W      = 6,
    parameter int ADDR_W   = 8,
    parameter int COLOUR_W = 6,
    parameter int CELLS    = 4,
    parameter int OFF_W    = 2
) (
    input logic           clk,
    input logic           reset,
    move_checker_if.slave bus
);

    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(CELLS - 1);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_PROBE = PROBE;
    localparam logic [1:0] S_DRAIN = DRAIN;

    localparam logic signed [X_W:0] XLIM = (X_W+1)'(BOARD_W);
    localparam logic signed [Y_W:0] YLIM = (Y_W+1)'(BOARD_H);

    logic [1:0]        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [1:0]        move_q, move_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [2:0]        blk_q, blk_d;
    logic [1:0]        rot_q, rot_d;
    logic [CELLS-1:0]  oob_q, oob_d;
    logic              hit_q, hit_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              bl_q, bl_d;
    logic              land_q, land_d;
    logic [X_W-1:0]    xo_q, xo_d;
    logic [Y_W-1:0]    yo_q, yo_d;
    logic [1:0]        ro_q, ro_d;

    logic st_idle, st_probe, st_drain;
    assign st_idle  = (state_q == S_IDLE);
    assign st_probe = (state_q == S_PROBE);
    assign st_drain = (state_q == S_DRAIN);

    logic [1:0]             tgt_rot;
    logic [CELLS*OFF_W-1:0] offx, offy;
    logic [COLOUR_W-1:0]    colour_unused;

    assign tgt_rot = (move_q == MOVE_ROT) ? rot_q + 2'd1 : rot_q;

    piece_offsets #(
        .CELLS    (CELLS),
        .OFF_W    (OFF_W),
        .COLOUR_W (COLOUR_W)
    ) u_offsets (
        .block_i  (blk_q),
        .rot_i    (tgt_rot),
        .offx_o   (offx),
        .offy_o   (offy),
        .colour_o (colour_unused)
    );

    logic signed [X_W:0] dx, tx;
    logic signed [Y_W:0] dy, ty;
    logic [OFF_W-1:0]    cur_ox, cur_oy;
    logic [X_W-1:0]      tgt_x;
    logic [Y_W-1:0]      tgt_y;
    logic                oob;
    logic [ADDR_W-1:0]   addr;

    always_comb begin
        dx = '0;
        if (move_q == MOVE_LEFT) begin
            dx = '1;
        end else if (move_q == MOVE_RIGHT) begin
            dx = (X_W+1)'(1);
        end
    end

    assign dy = (move_q == MOVE_DOWN) ? (Y_W+1)'(1) : '0;

    assign cur_ox = offx[idx_q*OFF_W +: OFF_W];
    assign cur_oy = offy[idx_q*OFF_W +: OFF_W];

    assign tx = $signed({1'b0, x_q}) + dx
              + $signed((X_W+1)'(cur_ox));
    assign ty = $signed({1'b0, y_q}) + dy
              + $signed((Y_W+1)'(cur_oy));

    assign tgt_x = X_W'($signed({1'b0, x_q}) + dx);
    assign tgt_y = Y_W'($signed({1'b0, y_q}) + dy);

    // A negative ty can only come from overflow of a huge anchor.
    assign oob = tx[X_W] || (tx >= XLIM)
              || ty[Y_W] || (ty >= YLIM);

    assign addr = ADDR_W'(int'(ty) * BOARD_W + int'(tx));

    // Read data lags the registered address by one cycle, so the
    // cell being judged is always one index behind the one probed.
    logic [IDX_W-1:0] samp_idx;
    logic             hit, blk_now;

    assign samp_idx = st_drain ? LAST : idx_q - IDX_W'(1);
    assign hit      = oob_q[samp_idx] | (|bus.ram_q);
    assign blk_now  = hit_q | hit;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        move_d  = move_q;
        x_d     = x_q;
        y_d     = y_q;
        blk_d   = blk_q;
        rot_d   = rot_q;
        oob_d   = oob_q;
        hit_d   = hit_q;
        addr_d  = addr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bl_d    = bl_q;
        land_d  = land_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        ro_d    = ro_q;
        unique case (1'b1)
            st_idle: begin
                if (bus.start) begin
                    move_d  = bus.move;
                    x_d     = bus.x_anchor;
                    y_d     = bus.y_anchor;
                    blk_d   = bus.block;
                    rot_d   = bus.rot;
                    idx_d   = '0;
                    oob_d   = '0;
                    hit_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_PROBE;
                end
            end
            st_probe: begin
                addr_d        = oob ? '0 : addr;
                oob_d[idx_q]  = oob;
                if (idx_q != '0) begin
                    hit_d = blk_now;
                end
                if (idx_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            st_drain: begin
                bl_d    = blk_now;
                land_d  = blk_now && (move_q == MOVE_DOWN);
                xo_d    = blk_now ? x_q : tgt_x;
                yo_d    = blk_now ? y_q : tgt_y;
                ro_d    = blk_now ? rot_q : tgt_rot;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            move_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            blk_q   <= '0;
            rot_q   <= '0;
            oob_q   <= '0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bl_q    <= 1'b0;
            land_q  <= 1'b0;
            xo_q    <= '0;
            yo_q    <= '0;
            ro_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            move_q  <= move_d;
            x_q     <= x_d;
            y_q     <= y_d;
            blk_q   <= blk_d;
            rot_q   <= rot_d;
            oob_q   <= oob_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bl_q    <= bl_d;
            land_q  <= land_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            ro_q    <= ro_d;
        end
    end

    assign bus.ram_addr = addr_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.blocked  = bl_q;
    assign bus.landed   = land_q;
    assign bus.x_out    = xo_q;
    assign bus.y_out    = yo_q;
    assign bus.rot_out  = ro_q;

endmodule

// File: tb/tb_move_checker.sv
// Scoreboard bench for move_checker on a 10x24 board.
// Directed requests push expectations; a monitor checks each done.
module tb_move_checker;
    import tetris_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    move_checker_if #(
        .X_W(5), .Y_W(6), .ADDR_W(8), .COLOUR_W(6)
    ) bus ();

    logic [5:0] mem [256];
    assign bus.ram_q = mem[bus.ram_addr];

    move_checker #(
        .BOARD_W(10), .BOARD_H(24), .X_W(5), .Y_W(6),
        .ADDR_W(8), .COLOUR_W(6), .CELLS(4), .OFF_W(2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       b;
        logic       l;
        logic [4:0] x;
        logic [5:0] y;
        logic [1:0] r;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    n_pass = 0;
    int    n_total = 0;
    int    addr_log[4];

    task automatic check(input string nm, input int got,
                         input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, got, want);
    endtask

    always @(negedge clk) begin
        if (!reset && bus.done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                exp_t  e;
                string nm;
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, ".blocked"}, int'(bus.blocked), int'(e.b));
                check({nm, ".landed"}, int'(bus.landed), int'(e.l));
                check({nm, ".x_out"}, int'(bus.x_out), int'(e.x));
                check({nm, ".y_out"}, int'(bus.y_out), int'(e.y));
                check({nm, ".rot_out"}, int'(bus.rot_out), int'(e.r));
            end
        end
    end

    task automatic req(input string nm, input logic [1:0] mv,
                       input int x, input int y, input int blk,
                       input int r, input int eb, input int el,
                       input int ex, input int ey, input int er);
        exp_t e;
        @(negedge clk);
        bus.move     = mv;
        bus.x_anchor = 5'(x);
        bus.y_anchor = 6'(y);
        bus.block    = 3'(blk);
        bus.rot      = 2'(r);
        bus.start    = 1'b1;
        e.b = 1'(eb);
        e.l = 1'(el);
        e.x = 5'(ex);
        e.y = 6'(ey);
        e.r = 2'(er);
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // lat counts negedges after the accepting edge; done must be
    // seen after edge 5.
    task automatic wait_done(input string nm, input int lat0);
        int lat;
        bit got;
        lat = lat0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            if (lat >= 1 && lat <= 4)
                addr_log[lat-1] = int'(bus.ram_addr);
            if (bus.done) got = 1'b1;
        end
        check({nm, ".latency"}, lat, 5);
    endtask

    task automatic check_addrs(input string nm, input int a0,
                               input int a1, input int a2,
                               input int a3);
        check({nm, ".addr0"}, addr_log[0], a0);
        check({nm, ".addr1"}, addr_log[1], a1);
        check({nm, ".addr2"}, addr_log[2], a2);
        check({nm, ".addr3"}, addr_log[3], a3);
    endtask

    task automatic check_zero(input string nm);
        check({nm, ".busy"}, int'(bus.busy), 0);
        check({nm, ".done"}, int'(bus.done), 0);
        check({nm, ".ram_addr"}, int'(bus.ram_addr), 0);
        check({nm, ".blocked"}, int'(bus.blocked), 0);
        check({nm, ".landed"}, int'(bus.landed), 0);
        check({nm, ".x_out"}, int'(bus.x_out), 0);
        check({nm, ".y_out"}, int'(bus.y_out), 0);
        check({nm, ".rot_out"}, int'(bus.rot_out), 0);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.move     = MOVE_DOWN;
        bus.x_anchor = '0;
        bus.y_anchor = '0;
        bus.block    = '0;
        bus.rot      = '0;
        for (int i = 0; i < 256; i++) mem[i] = 6'h00;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        reset = 1'b0;

        req("o_down", MOVE_DOWN, 4, 0, 1, 0, 0, 0, 4, 1, 0);
        wait_done("o_down", 0);
        check_addrs("o_down", 14, 15, 24, 25);

        mem[0] = 6'h3F;
        req("left_wall", MOVE_LEFT, 0, 5, 1, 0, 1, 0, 0, 5, 0);
        wait_done("left_wall", 0);
        check_addrs("left_wall", 0, 50, 0, 60);
        mem[0] = 6'h00;

        req("floor", MOVE_DOWN, 4, 22, 1, 0, 1, 1, 4, 22, 0);
        wait_done("floor", 0);

        mem[114] = 6'h3F;
        req("right_hit", MOVE_RIGHT, 3, 10, 1, 0, 1, 0, 3, 10, 0);
        wait_done("right_hit", 0);
        mem[114] = 6'h00;
        req("right_free", MOVE_RIGHT, 3, 10, 1, 0, 0, 0, 4, 10, 0);
        wait_done("right_free", 0);

        req("rot_wall", MOVE_ROT, 8, 2, 0, 0, 1, 0, 8, 2, 0);
        wait_done("rot_wall", 0);
        req("rot_wrap", MOVE_ROT, 3, 5, 0, 3, 0, 0, 3, 5, 0);
        wait_done("rot_wrap", 0);
        req("rot_mid", MOVE_ROT, 3, 5, 0, 0, 0, 0, 3, 5, 1);
        wait_done("rot_mid", 0);

        @(negedge clk);
        bus.move     = MOVE_DOWN;
        bus.x_anchor = 5'd4;
        bus.y_anchor = 6'd0;
        bus.block    = SHAPE_O;
        bus.rot      = 2'd0;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero("abort");
        reset = 1'b0;
        repeat (8) @(negedge clk);
        check("abort.idle_busy", int'(bus.busy), 0);

        req("after_reset", MOVE_DOWN, 4, 10, 2, 0, 0, 0, 4, 11, 0);
        wait_done("after_reset", 0);

        req("busy_start", MOVE_LEFT, 2, 3, 5, 0, 0, 0, 1, 3, 0);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.x_anchor = 5'd7;
        bus.move     = MOVE_RIGHT;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("busy_start", 2);

        repeat (10) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
